rs_entry: RTL and testbench
===========================

Name: rs_entry

Overview:
- Single reservation-station entry in the out-of-order issue stage.
- Allocated from rename/dispatch with opcode, destination tag and two source operands.
- Each operand arrives either as a value or as a pending tag. The entry snoops the common data bus (CDB) to capture pending operands.
- Presents the instruction downstream to select/execute through a valid/ready handshake.

Parameters:
DATA_W, 32, operand and CDB value width
TAG_W, 6, physical/ROB tag width
OPC_W, 4, opcode width
AGE_W, 4, age counter width (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous squash, returns entry to EMPTY
alloc_valid  in  1  dispatch offers an instruction
alloc_ready  out  1  entry is EMPTY and accepts allocation
alloc_opcode  in  OPC_W  opcode
alloc_dest_tag  in  TAG_W  destination tag
alloc_a_rdy  in  1  operand A value already present
alloc_a_val  in  DATA_W  operand A value (meaningful when alloc_a_rdy)
alloc_a_tag  in  TAG_W  operand A producer tag (meaningful when !alloc_a_rdy)
alloc_b_rdy  in  1  operand B value already present
alloc_b_val  in  DATA_W  operand B value
alloc_b_tag  in  TAG_W  operand B producer tag
cdb_valid  in  1  CDB broadcast valid this cycle
cdb_tag  in  TAG_W  broadcast tag
cdb_val  in  DATA_W  broadcast value
issue_valid  out  1  entry holds a fully ready instruction
issue_ready  in  1  downstream accepts issue
issue_opcode  out  OPC_W  held opcode
issue_dest_tag  out  TAG_W  held destination tag
issue_a  out  DATA_W  operand A value
issue_b  out  DATA_W  operand B value
issue_age  out  AGE_W  cycles spent in READY (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=EMPTY; all held fields, operand-ready bits and outputs are 0; alloc_ready=1 once reset deasserts.
- States: EMPTY, WAIT, READY. alloc_ready = (state==EMPTY); issue_valid = (state==READY). Both are registered-state decodes with no combinational path from inputs.
- EMPTY: on alloc_valid, latch all alloc fields.
  - Same-cycle CDB bypass: for each operand with !alloc_x_rdy, cdb_valid and cdb_tag==alloc_x_tag, latch cdb_val and mark that operand ready.
  - Next state is READY if both operands are ready after bypass, else WAIT.
- WAIT: each not-ready operand whose tag matches a valid CDB captures cdb_val and sets its ready bit.
  - A single broadcast may satisfy both operands when the tags are equal.
  - Transition to READY on the edge where both ready bits become set. Wake-up-to-issue_valid latency is 1 cycle after the CDB cycle.
  - Already-ready operands never change.
- READY: outputs are held stable while issue_valid && !issue_ready. On issue_valid && issue_ready, next state is EMPTY.
  - alloc_ready rises the following cycle. There is no same-cycle free-and-reallocate.
- flush: next state EMPTY from any state; ready bits cleared. Priority order: reset > flush > issue/alloc/CDB.
- CDB activity while EMPTY or READY is ignored.
- Reset asserted mid-operation: immediate EMPTY, no pending capture completes.
- Operand hold/capture is a per-bit 2:1 select between the held value and cdb_val, with select = capture enable.
- Tag compare is full TAG_W equality. There is no tag wrap handling; uniqueness is guaranteed by rename.

Optional Feature:
Macro RS_AGE_COUNTER_EN.
- With the macro: issue_age clears to 0 on entry to READY, increments each cycle in READY, and saturates at 2^AGE_W-1. It clears on issue, flush or reset. Select logic uses it for oldest-first arbitration.
- Without the macro: issue_age is tied to 0 and no counter flops exist.

Decomposition:
- Package rs_pkg holds:
  - rs_state_t enum {EMPTY, WAIT, READY};
  - default width constants DATA_W/TAG_W/OPC_W/AGE_W;
  - packed struct rs_operand_t {rdy, tag, val}.
- One sub-module, rs_operand_slot, per operand.
  - Inputs: load, load values, CDB snoop.
  - Outputs: rdy, val.
  - Contains the tag compare and the hold/capture select.
  - rs_entry instantiates two of them plus the state machine.

Test Plan:
1. Alloc opcode=3, dest=5, A rdy val=0x11, B rdy val=0x22 -> issue_valid next cycle, issue_a=0x11, issue_b=0x22; issue_ready=1 -> EMPTY, alloc_ready=1 the cycle after.
2. Alloc A tag=7 pending, B ready; CDB tag=7 val=0xDEAD two cycles later -> issue_valid 1 cycle after broadcast, issue_a=0xDEAD; CDB tag=9 earlier is ignored.
3. Alloc with A tag=4 while same-cycle CDB tag=4 val=0xBEEF, B ready -> state READY next cycle, issue_a=0xBEEF (bypass).
4. A and B both tag=12; single CDB tag=12 val=0x55 -> both operands=0x55, issue_valid next cycle.
5. READY with issue_ready=0 for 20 cycles -> outputs stable; with RS_AGE_COUNTER_EN and AGE_W=4, issue_age saturates at 15; flush -> EMPTY, issue_age=0.
6. Assert reset asynchronously mid-WAIT -> all outputs 0 immediately, later CDB match has no effect, alloc_ready=1 after release.

Source files
------------

// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared types and default widths for the reservation-station entry
package rs_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int OPC_W  = 4;
  localparam int AGE_W  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } rs_state_t;

  typedef struct packed {
    logic              rdy;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } rs_operand_t;

endpackage

// File: rtl/rs_entry_if.sv
// rtl/rs_entry_if.sv - dispatch, CDB snoop and issue signals of one reservation-station entry
interface rs_entry_if #(
  parameter int DATA_W = rs_pkg::DATA_W,
  parameter int TAG_W  = rs_pkg::TAG_W,
  parameter int OPC_W  = rs_pkg::OPC_W,
  parameter int AGE_W  = rs_pkg::AGE_W
) ();

  logic              flush;

  logic              alloc_valid;
  logic              alloc_ready;
  logic [OPC_W-1:0]  alloc_opcode;
  logic [TAG_W-1:0]  alloc_dest_tag;
  logic              alloc_a_rdy;
  logic [DATA_W-1:0] alloc_a_val;
  logic [TAG_W-1:0]  alloc_a_tag;
  logic              alloc_b_rdy;
  logic [DATA_W-1:0] alloc_b_val;
  logic [TAG_W-1:0]  alloc_b_tag;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_val;

  logic              issue_valid;
  logic              issue_ready;
  logic [OPC_W-1:0]  issue_opcode;
  logic [TAG_W-1:0]  issue_dest_tag;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [AGE_W-1:0]  issue_age;

  // dispatch / CDB / select side
  modport master (
    output flush,
    output alloc_valid, alloc_opcode, alloc_dest_tag,
    output alloc_a_rdy, alloc_a_val, alloc_a_tag,
    output alloc_b_rdy, alloc_b_val, alloc_b_tag,
    input  alloc_ready,
    output cdb_valid, cdb_tag, cdb_val,
    output issue_ready,
    input  issue_valid, issue_opcode, issue_dest_tag, issue_a, issue_b, issue_age
  );

  // entry side
  modport slave (
    input  flush,
    input  alloc_valid, alloc_opcode, alloc_dest_tag,
    input  alloc_a_rdy, alloc_a_val, alloc_a_tag,
    input  alloc_b_rdy, alloc_b_val, alloc_b_tag,
    output alloc_ready,
    input  cdb_valid, cdb_tag, cdb_val,
    input  issue_ready,
    output issue_valid, issue_opcode, issue_dest_tag, issue_a, issue_b, issue_age
  );

endinterface

// File: rtl/rs_operand_slot.sv
// rtl/rs_operand_slot.sv - one source operand: load, CDB tag snoop and value hold/capture
module rs_operand_slot #(
  parameter int DATA_W = rs_pkg::DATA_W,
  parameter int TAG_W  = rs_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              load_rdy,
  input  logic [DATA_W-1:0] load_val,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic              snoop,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              rdy,
  output logic              rdy_next,
  output logic [DATA_W-1:0] val
);

  logic              rdy_q, rdy_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              capture;
  logic              bypass;

  // Next operand state: load (with same-cycle CDB bypass) or wake-up capture while waiting
  always_comb begin
    bypass  = !load_rdy && cdb_valid && (cdb_tag == load_tag);
    capture = snoop && !clear && !rdy_q && cdb_valid && (cdb_tag == tag_q);
    rdy_d   = rdy_q;
    tag_d   = tag_q;
    val_d   = capture ? cdb_val : val_q;
    if (clear) begin
      rdy_d = 1'b0;
    end else if (load) begin
      tag_d = load_tag;
      rdy_d = load_rdy || bypass;
      val_d = bypass ? cdb_val : load_val;
    end else if (capture) begin
      rdy_d = 1'b1;
    end
  end

  // Operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q <= 1'b0;
      tag_q <= '0;
      val_q <= '0;
    end else begin
      rdy_q <= rdy_d;
      tag_q <= tag_d;
      val_q <= val_d;
    end
  end

  assign rdy      = rdy_q;
  assign rdy_next = rdy_d;
  assign val      = val_q;

endmodule

// File: rtl/rs_entry.sv
// rtl/rs_entry.sv - reservation-station entry; RS_AGE_COUNTER_EN adds the issue_age counter
module rs_entry #(
  parameter int DATA_W = rs_pkg::DATA_W,
  parameter int TAG_W  = rs_pkg::TAG_W,
  parameter int OPC_W  = rs_pkg::OPC_W,
  parameter int AGE_W  = rs_pkg::AGE_W
) (
  input  logic       clk,
  input  logic       reset,
  rs_entry_if.slave  bus
);
  import rs_pkg::*;

  rs_state_t         state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [TAG_W-1:0]  dest_q, dest_d;
  logic              load, clear, snoop, issue_fire;
  logic              a_rdy, a_rdy_next, b_rdy, b_rdy_next;
  logic [DATA_W-1:0] a_val, b_val;

  // Control decode from registered state; flush blocks a same-cycle allocation
  always_comb begin
    load       = (state_q == EMPTY) && bus.alloc_valid && !bus.flush;
    snoop      = (state_q == WAIT);
    issue_fire = (state_q == READY) && bus.issue_ready;
    clear      = bus.flush || issue_fire;
  end

  rs_operand_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot_a (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_rdy(bus.alloc_a_rdy), .load_val(bus.alloc_a_val), .load_tag(bus.alloc_a_tag),
    .snoop(snoop), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
    .rdy(a_rdy), .rdy_next(a_rdy_next), .val(a_val)
  );

  rs_operand_slot #(.DATA_W(DATA_W), .TAG_W(TAG_W)) u_slot_b (
    .clk(clk), .reset(reset), .clear(clear), .load(load),
    .load_rdy(bus.alloc_b_rdy), .load_val(bus.alloc_b_val), .load_tag(bus.alloc_b_tag),
    .snoop(snoop), .cdb_valid(bus.cdb_valid), .cdb_tag(bus.cdb_tag), .cdb_val(bus.cdb_val),
    .rdy(b_rdy), .rdy_next(b_rdy_next), .val(b_val)
  );

  // Next state and held instruction fields
  always_comb begin
    state_d = state_q;
    opc_d   = load ? bus.alloc_opcode : opc_q;
    dest_d  = load ? bus.alloc_dest_tag : dest_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (bus.alloc_valid) state_d = (a_rdy_next && b_rdy_next) ? READY : WAIT;
        WAIT:    if (a_rdy_next && b_rdy_next) state_d = READY;
        READY:   if (bus.issue_ready) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      opc_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      dest_q  <= dest_d;
    end
  end

  // alloc_ready is held low while reset is asserted so every output reads 0 during reset
  assign bus.alloc_ready    = (state_q == EMPTY) && !reset;
  assign bus.issue_valid    = (state_q == READY) && a_rdy && b_rdy;
  assign bus.issue_opcode   = opc_q;
  assign bus.issue_dest_tag = dest_q;
  assign bus.issue_a        = a_val;
  assign bus.issue_b        = b_val;

`ifdef RS_AGE_COUNTER_EN
  logic [AGE_W-1:0] age_q, age_d;

  // Age counts cycles spent in READY, zero on entry, saturating at all-ones
  always_comb begin
    age_d = '0;
    if ((state_q == READY) && (state_d == READY)) begin
      age_d = (age_q == {AGE_W{1'b1}}) ? age_q : age_q + {{(AGE_W-1){1'b0}}, 1'b1};
    end
  end

  // Age register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

  assign bus.issue_age = age_q;
`else
  assign bus.issue_age = {AGE_W{1'b0}};
`endif

endmodule

// File: tb/tb_rs_entry.sv
// tb/tb_rs_entry.sv - directed and randomized checks of rs_entry against a behavioural model
module tb_rs_entry;
  import rs_pkg::*;

  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rs_entry_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OPC_W(OPC_W), .AGE_W(AGE_W)) bus ();

  rs_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .OPC_W(OPC_W), .AGE_W(AGE_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: an occupied slot with two operands; it issues when both are present
  bit               m_busy;
  rs_operand_t      m_op [2];
  logic [OPC_W-1:0] m_opc;
  logic [TAG_W-1:0] m_dest;
  int               m_age;

  function automatic bit m_ready();
    return m_busy && m_op[0].rdy && m_op[1].rdy;
  endfunction

  function automatic int exp_age();
`ifdef RS_AGE_COUNTER_EN
    return (m_age > AGE_MAX) ? AGE_MAX : m_age;
`else
    return 0;
`endif
  endfunction

  function automatic rs_operand_t load_op(input bit rdy, input logic [DATA_W-1:0] v,
                                          input logic [TAG_W-1:0] t);
    rs_operand_t op;
    op.tag = t;
    op.rdy = rdy || (bus.cdb_valid && bus.cdb_tag == t);
    op.val = rdy ? v : bus.cdb_val;
    return op;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_op[0] = '0;
    m_op[1] = '0;
    m_opc = '0;
    m_dest = '0;
    m_age = 0;
  endtask

  task automatic model_step();
    bit was_ready;
    was_ready = m_ready();
    if (bus.flush) begin
      m_busy = 0;
      m_op[0].rdy = 0;
      m_op[1].rdy = 0;
    end else if (was_ready) begin
      if (bus.issue_ready) begin
        m_busy = 0;
        m_op[0].rdy = 0;
        m_op[1].rdy = 0;
      end
    end else if (m_busy) begin
      for (int i = 0; i < 2; i++) begin
        if (!m_op[i].rdy && bus.cdb_valid && bus.cdb_tag == m_op[i].tag) begin
          m_op[i].rdy = 1;
          m_op[i].val = bus.cdb_val;
        end
      end
    end else if (bus.alloc_valid) begin
      m_busy = 1;
      m_opc = bus.alloc_opcode;
      m_dest = bus.alloc_dest_tag;
      m_op[0] = load_op(bus.alloc_a_rdy, bus.alloc_a_val, bus.alloc_a_tag);
      m_op[1] = load_op(bus.alloc_b_rdy, bus.alloc_b_val, bus.alloc_b_tag);
    end
    m_age = (was_ready && m_ready()) ? m_age + 1 : 0;
  endtask

  task automatic compare_all(input string ctx);
    check({ctx, ".alloc_ready"}, 64'(bus.alloc_ready), 64'(!m_busy));
    check({ctx, ".issue_valid"}, 64'(bus.issue_valid), 64'(m_ready()));
    check({ctx, ".issue_age"}, 64'(bus.issue_age), 64'(exp_age()));
    if (m_ready()) begin
      check({ctx, ".issue_opcode"}, 64'(bus.issue_opcode), 64'(m_opc));
      check({ctx, ".issue_dest_tag"}, 64'(bus.issue_dest_tag), 64'(m_dest));
      check({ctx, ".issue_a"}, 64'(bus.issue_a), 64'(m_op[0].val));
      check({ctx, ".issue_b"}, 64'(bus.issue_b), 64'(m_op[1].val));
    end
  endtask

  task automatic tick(input string ctx);
    model_step();
    @(posedge clk);
    #1;
    compare_all(ctx);
  endtask

  task automatic idle();
    bus.flush = 0;
    bus.alloc_valid = 0;
    bus.alloc_opcode = '0;
    bus.alloc_dest_tag = '0;
    bus.alloc_a_rdy = 0;
    bus.alloc_a_val = '0;
    bus.alloc_a_tag = '0;
    bus.alloc_b_rdy = 0;
    bus.alloc_b_val = '0;
    bus.alloc_b_tag = '0;
    bus.cdb_valid = 0;
    bus.cdb_tag = '0;
    bus.cdb_val = '0;
    bus.issue_ready = 0;
  endtask

  task automatic alloc(input int opc, input int dest, input bit ar, input int av, input int at,
                       input bit br, input int bv, input int bt);
    bus.alloc_valid = 1;
    bus.alloc_opcode = OPC_W'(opc);
    bus.alloc_dest_tag = TAG_W'(dest);
    bus.alloc_a_rdy = ar;
    bus.alloc_a_val = DATA_W'(av);
    bus.alloc_a_tag = TAG_W'(at);
    bus.alloc_b_rdy = br;
    bus.alloc_b_val = DATA_W'(bv);
    bus.alloc_b_tag = TAG_W'(bt);
  endtask

  task automatic cdb(input int t, input int v);
    bus.cdb_valid = 1;
    bus.cdb_tag = TAG_W'(t);
    bus.cdb_val = DATA_W'(v);
  endtask

  task automatic check_all_zero(input string ctx);
    check({ctx, ".alloc_ready"}, 64'(bus.alloc_ready), 64'd0);
    check({ctx, ".issue_valid"}, 64'(bus.issue_valid), 64'd0);
    check({ctx, ".issue_opcode"}, 64'(bus.issue_opcode), 64'd0);
    check({ctx, ".issue_dest_tag"}, 64'(bus.issue_dest_tag), 64'd0);
    check({ctx, ".issue_a"}, 64'(bus.issue_a), 64'd0);
    check({ctx, ".issue_b"}, 64'(bus.issue_b), 64'd0);
    check({ctx, ".issue_age"}, 64'(bus.issue_age), 64'd0);
  endtask

  initial begin
    idle();
    reset = 1;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    #1;
    check("reset_release.alloc_ready", 64'(bus.alloc_ready), 64'd1);

    // both operands present at dispatch
    alloc(3, 5, 1, 'h11, 0, 1, 'h22, 0);
    tick("t1_alloc");
    check("t1.issue_valid", 64'(bus.issue_valid), 64'd1);
    check("t1.issue_a", 64'(bus.issue_a), 64'h11);
    check("t1.issue_b", 64'(bus.issue_b), 64'h22);
    check("t1.issue_opcode", 64'(bus.issue_opcode), 64'd3);
    check("t1.issue_dest", 64'(bus.issue_dest_tag), 64'd5);
    idle();
    bus.issue_ready = 1;
    tick("t1_issue");
    check("t1.alloc_ready_after", 64'(bus.alloc_ready), 64'd1);

    // A waits on tag 7; a non-matching broadcast first
    idle();
    alloc(1, 2, 0, 0, 7, 1, 'h33, 0);
    tick("t2_alloc");
    idle();
    cdb(9, 'h999);
    tick("t2_cdb9");
    check("t2.not_ready_after_tag9", 64'(bus.issue_valid), 64'd0);
    cdb(7, 'hDEAD);
    tick("t2_cdb7");
    check("t2.issue_valid", 64'(bus.issue_valid), 64'd1);
    check("t2.issue_a", 64'(bus.issue_a), 64'hDEAD);
    idle();
    bus.issue_ready = 1;
    tick("t2_issue");

    // same-cycle bypass at allocation
    idle();
    alloc(4, 6, 0, 0, 4, 1, 'h44, 0);
    cdb(4, 'hBEEF);
    tick("t3_bypass");
    check("t3.issue_valid", 64'(bus.issue_valid), 64'd1);
    check("t3.issue_a", 64'(bus.issue_a), 64'hBEEF);
    idle();
    bus.issue_ready = 1;
    tick("t3_issue");

    // one broadcast wakes both operands
    idle();
    alloc(5, 9, 0, 0, 12, 0, 0, 12);
    tick("t4_alloc");
    check("t4.waiting", 64'(bus.issue_valid), 64'd0);
    idle();
    cdb(12, 'h55);
    tick("t4_cdb");
    check("t4.issue_valid", 64'(bus.issue_valid), 64'd1);
    check("t4.issue_a", 64'(bus.issue_a), 64'h55);
    check("t4.issue_b", 64'(bus.issue_b), 64'h55);

    // held in READY under backpressure while the CDB and dispatch are noisy
    for (int i = 0; i < 20; i++) begin
      idle();
      bus.cdb_valid = 1'($urandom_range(1));
      bus.cdb_tag = TAG_W'(12);
      bus.cdb_val = DATA_W'($urandom);
      bus.alloc_valid = 1'($urandom_range(1));
      bus.alloc_a_rdy = 1;
      bus.alloc_a_val = DATA_W'($urandom);
      tick("t5_hold");
      check("t5.issue_a_stable", 64'(bus.issue_a), 64'h55);
    end
`ifdef RS_AGE_COUNTER_EN
    check("t5.age_saturated", 64'(bus.issue_age), 64'(AGE_MAX));
`else
    check("t5.age_tied", 64'(bus.issue_age), 64'd0);
`endif
    idle();
    bus.flush = 1;
    tick("t5_flush");
    check("t5.flush_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("t5.flush_age", 64'(bus.issue_age), 64'd0);

    // asynchronous reset in the middle of WAIT
    idle();
    alloc(7, 3, 0, 0, 20, 0, 0, 21);
    tick("t6_alloc");
    idle();
    #2;
    reset = 1;
    #1;
    check_all_zero("t6_async_reset");
    model_reset();
    cdb(20, 'h1234);
    @(posedge clk);
    #1;
    check_all_zero("t6_in_reset");
    reset = 0;
    cdb(21, 'h5678);
    tick("t6_after_release");
    check("t6.alloc_ready", 64'(bus.alloc_ready), 64'd1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      bus.flush = ($urandom_range(99) < 3);
      bus.alloc_valid = 1'($urandom_range(1));
      bus.alloc_opcode = OPC_W'($urandom);
      bus.alloc_dest_tag = TAG_W'($urandom);
      bus.alloc_a_rdy = 1'($urandom_range(1));
      bus.alloc_a_val = DATA_W'($urandom);
      bus.alloc_a_tag = TAG_W'($urandom_range(7));
      bus.alloc_b_rdy = 1'($urandom_range(1));
      bus.alloc_b_val = DATA_W'($urandom);
      bus.alloc_b_tag = TAG_W'($urandom_range(7));
      bus.cdb_valid = 1'($urandom_range(1));
      bus.cdb_tag = TAG_W'($urandom_range(7));
      bus.cdb_val = DATA_W'($urandom);
      bus.issue_ready = ($urandom_range(9) < 3);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
